aer_event_fifo: RTL and testbench
=================================

# aer_event_fifo

Output buffer for address-event words leaving the pixel arbitration hierarchy. Every cycle the hierarchy asserts its active/enable strobe, the block captures the encoded event word (row, column, timestamp, polarity) into a circular FIFO. It presents buffered words to the off-chip/readout side over a valid/ready handshake. The hierarchy cannot be stalled, so when the FIFO is full the event is dropped and counted, and a sticky overflow flag is raised.

## Interface
- DATA_W, default WIDTH (lib_arbiter_pkg): event word width.
- DEPTH, default 16: FIFO entries; power of two, ≥2.
- AFULL_TH, default 12: almost-full threshold, 1..DEPTH-1.
- CNT_W, default 16: drop counter width.

- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset
- evt_valid_i  in  1  event strobe (hierarchy active)
- evt_data_i  in  DATA_W  encoded event word
- evt_ready_o  out  1  FIFO can accept this cycle (status only)
- almost_full_o  out  1  level ≥ AFULL_TH
- out_valid_o  out  1  head word available
- out_data_o  out  DATA_W  head word
- out_ready_i  in  1  consumer accepts head
- level_o  out  $clog2(DEPTH)+1  entries stored
- drop_cnt_o  out  CNT_W  saturating dropped-event count
- overflow_o  out  1  sticky: ≥1 drop since last clear
- clr_i  in  1  sync clear of drop_cnt_o/overflow_o
- flush_i  in  1  sync empty of FIFO

## Operation
- rd = out_valid_o & out_ready_i. wr = evt_valid_i & (level < DEPTH | rd).
- Accept rule: write is accepted when not full, or when full with a read in the same cycle.
- Drop rule: a drop occurs when evt_valid_i is high and wr is low. drop_cnt_o increments by 1 and saturates at 2^CNT_W-1. overflow_o is set to 1.
- level update: level += wr - rd. Pointers wrap modulo DEPTH. Extra MSB/compare logic distinguishes full from empty.
- out_data_o = mem[rd_ptr], which is first-word-fall-through. While out_valid_o & ~out_ready_i, out_data_o and out_valid_o stay stable.
- evt_ready_o = (level < DEPTH), combinational from registered level. out_valid_o = (level ≠ 0).
- flush_i: pointers and level go to 0 next cycle. A write or read in the same cycle is ignored. drop_cnt_o and overflow_o are untouched.
- clr_i: drop_cnt_o ← 0 and overflow_o ← 0. If a drop occurs in the same cycle, the result is drop_cnt_o = 1 and overflow_o = 1.
- flush_i and clr_i may be asserted together; each acts independently.

## Timing
- Reset (reset_i low, async) sets:
  - level_o = 0, out_valid_o = 0, out_data_o = 0
  - drop_cnt_o = 0, overflow_o = 0, almost_full_o = 0
  - evt_ready_o = 1
  - Memory contents need not be reset; out_data_o is forced to 0 while empty.
- Reset deassertion is synchronized externally. The first write is possible in the first clock after release.
- Write latency: an event accepted in cycle N into an empty FIFO gives out_valid_o = 1 with that word at N+1.
- Read: a handshake in cycle N exposes the next word, or deasserts valid, at N+1.
- Throughput: 1 write and 1 read per cycle sustained, including at full.
- Status timing: almost_full_o, level_o and drop_cnt_o are registered and reflect state after the cycle's write/read.
- Reset asserted mid-operation: all contents are discarded immediately; no partial word is output.

## Structure
- lib_arbiter_pkg supplies WIDTH and the event word field layout (x, y, timestamp, polarity). Add AER_FIFO_DEPTH and AER_DROP_CNT_W defaults there.
- Split into one sub-module, aer_fifo_mem: DEPTH×DATA_W register array with write port and combinational read port.
- Pointers, level, handshake, drop and flag logic stay in aer_event_fifo.
- Instantiated in the top level fed by data_out_o and the hierarchy's active strobe.

## Test plan
- Basic pass-through: after reset, write 0xA5 at cycle 1 with out_ready_i = 1 → out_valid_o = 1 with 0xA5 at cycle 2, level_o back to 0 at cycle 3.
- Fill and drop: out_ready_i = 0, 20 consecutive events at DEPTH = 16 →
  - level_o = 16, evt_ready_o = 0, almost_full_o high from the 12th write
  - drop_cnt_o = 4, overflow_o = 1
  - drained order equals the first 16 words.
- Full with simultaneous read/write: full, out_ready_i = 1 and evt_valid_i = 1 for 10 cycles → no drops, level_o stays 16, output order preserved.
- Backpressure stability: toggle out_ready_i randomly with continuous writes below full → out_data_o is constant whenever valid & ~ready, and every accepted word is read exactly once in order.
- Clear/flush corner: clr_i coincident with a drop → drop_cnt_o = 1. flush_i with evt_valid_i high → level_o = 0 next cycle and the event is not stored. Saturation: CNT_W = 4, 20 drops → drop_cnt_o = 15.
- Async reset mid-burst: assert reset_i low between clock edges with level_o = 7 → all outputs go to reset values without a clock edge, and the FIFO reads empty after release.

Source files
------------

// File: rtl/lib_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lib_arbiter_pkg
//  Description : Shared definitions for the pixel arbitration hierarchy.
//                Defines the address-event word layout (x, y, timestamp,
//                polarity), its total WIDTH, and the default sizing of the
//                event output FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package lib_arbiter_pkg;

    // Event word field widths
    localparam int X_W   = 8;
    localparam int Y_W   = 8;
    localparam int TS_W  = 15;
    localparam int POL_W = 1;

    // Total encoded event word width
    localparam int WIDTH = X_W + Y_W + TS_W + POL_W;

    // Output FIFO defaults
    localparam int AER_FIFO_DEPTH = 16;
    localparam int AER_AFULL_TH   = 12;
    localparam int AER_DROP_CNT_W = 16;

    // Event word layout, MSB first: y, x, timestamp, polarity
    typedef struct packed {
        logic [Y_W-1:0]  y;
        logic [X_W-1:0]  x;
        logic [TS_W-1:0] ts;
        logic            pol;
    } aer_event_t;

    // Builds an encoded event word from its fields
    function automatic logic [WIDTH-1:0] aer_pack(
        input logic [Y_W-1:0]  y,
        input logic [X_W-1:0]  x,
        input logic [TS_W-1:0] ts,
        input logic            pol
    );
        aer_event_t ev;
        ev.y   = y;
        ev.x   = x;
        ev.ts  = ts;
        ev.pol = pol;
        return ev;
    endfunction

endpackage : lib_arbiter_pkg
`default_nettype wire

// File: rtl/aer_event_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : aer_event_fifo_if
//  Description : Handshake bundle of the AER event FIFO.
//                Write side : evt_valid_i / evt_data_i in, evt_ready_o status.
//                Read side  : out_valid_o / out_data_o out, out_ready_i in.
//                Modport slave is the FIFO; modport master is the
//                producer/consumer environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface aer_event_fifo_if
    import lib_arbiter_pkg::*;
#(
    parameter int DATA_W = WIDTH
);
    logic              evt_valid_i;
    logic [DATA_W-1:0] evt_data_i;
    logic              evt_ready_o;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic              out_ready_i;

    modport slave (
        input  evt_valid_i,
        input  evt_data_i,
        output evt_ready_o,
        output out_valid_o,
        output out_data_o,
        input  out_ready_i
    );

    modport master (
        output evt_valid_i,
        output evt_data_i,
        input  evt_ready_o,
        input  out_valid_o,
        input  out_data_o,
        output out_ready_i
    );

endinterface : aer_event_fifo_if
`default_nettype wire

// File: rtl/aer_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : aer_fifo_mem
//  Description : DEPTH x DATA_W register array storage for the event FIFO.
//                One synchronous write port, one combinational read port.
//                Contents are not reset; the FIFO masks the read data while
//                it is empty.
//  Ports       : clk_i      - clock
//                wr_en_i    - write strobe
//                wr_addr_i  - write address
//                wr_data_i  - write data
//                rd_addr_i  - read address
//                rd_data_o  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  wire logic                     clk_i,
    input  wire logic                     wr_en_i,
    input  wire logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0]        wr_data_i,
    input  wire logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic      [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule : aer_fifo_mem
`default_nettype wire

// File: rtl/aer_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : aer_event_fifo
//  Description : First-word-fall-through circular FIFO buffering address
//                events leaving the arbitration hierarchy. The hierarchy
//                cannot be stalled: an event arriving while the FIFO is full
//                (and no read frees a slot in the same cycle) is dropped,
//                counted in a saturating counter and flagged in a sticky
//                overflow bit.
//  Ports       : clk_i         - clock
//                reset_i       - asynchronous active-low reset
//                bus           - event write / readout handshake (slave)
//                almost_full_o - registered level >= AFULL_TH
//                level_o       - registered number of stored entries
//                drop_cnt_o    - saturating dropped-event count
//                overflow_o    - sticky drop flag
//                clr_i         - synchronous clear of drop_cnt_o/overflow_o
//                flush_i       - synchronous empty of the FIFO
//  Revision    : 1.0 - initial release
// ============================================================================
module aer_event_fifo
    import lib_arbiter_pkg::*;
#(
    parameter int DATA_W   = WIDTH,
    parameter int DEPTH    = AER_FIFO_DEPTH,
    parameter int AFULL_TH = AER_AFULL_TH,
    parameter int CNT_W    = AER_DROP_CNT_W
) (
    input  wire logic                   clk_i,
    input  wire logic                   reset_i,
    aer_event_fifo_if.slave             bus,
    output logic                        almost_full_o,
    output logic [$clog2(DEPTH):0]      level_o,
    output logic [CNT_W-1:0]            drop_cnt_o,
    output logic                        overflow_o,
    input  wire logic                   clr_i,
    input  wire logic                   flush_i
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    localparam logic [c_LVL_W-1:0] c_DEPTH_LVL = c_LVL_W'(DEPTH);
    localparam logic [c_LVL_W-1:0] c_AFULL_LVL = c_LVL_W'(AFULL_TH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE   = c_LVL_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_almost_full;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic               r_overflow;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic               w_out_valid;
    logic               w_not_full;
    logic               w_rd;
    logic               w_wr;
    logic               w_drop;
    logic               w_wr_commit;
    logic               w_rd_commit;
    logic [c_LVL_W-1:0] w_level_nxt;
    logic [DATA_W-1:0]  w_mem_rd_data;

    assign w_out_valid = (r_level != '0);
    assign w_not_full  = (r_level != c_DEPTH_LVL);
    assign w_rd        = w_out_valid & bus.out_ready_i;

    // A full FIFO still accepts a word when the head leaves in the same
    // cycle; the incoming word lands in the slot being vacated.
    assign w_wr        = bus.evt_valid_i & (w_not_full | w_rd);
    assign w_drop      = bus.evt_valid_i & ~w_wr;

    // Flush discards any same-cycle transfer; the drop decision above is
    // independent of flush so the statistics stay consistent.
    assign w_wr_commit = w_wr & ~flush_i;
    assign w_rd_commit = w_rd & ~flush_i;

    always_comb begin
        w_level_nxt = r_level;
        if (flush_i) begin
            w_level_nxt = '0;
        end else begin
            case ({w_wr_commit, w_rd_commit})
                2'b10:   w_level_nxt = r_level + c_LVL_ONE;
                2'b01:   w_level_nxt = r_level - c_LVL_ONE;
                default: w_level_nxt = r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pointers, level and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_nxt;
            r_almost_full <= (w_level_nxt >= c_AFULL_LVL);
            if (flush_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                // DEPTH is a power of two, so natural wrap is modulo DEPTH
                if (w_wr_commit) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_rd_commit) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop statistics. A drop coincident with a clear is kept, so the
    // result is a count of one with the flag set.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (clr_i) begin
            r_drop_cnt <= w_drop ? c_CNT_ONE : '0;
            r_overflow <= w_drop;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    aer_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (w_wr_commit),
        .wr_addr_i (r_wr_ptr),
        .wr_data_i (bus.evt_data_i),
        .rd_addr_i (r_rd_ptr),
        .rd_data_o (w_mem_rd_data)
    );

    // ------------------------------------------------------------------
    // Outputs. Head data is masked while empty so stale memory contents
    // never appear on the bus, including right after reset.
    // ------------------------------------------------------------------
    assign bus.evt_ready_o = w_not_full;
    assign bus.out_valid_o = w_out_valid;
    assign bus.out_data_o  = w_out_valid ? w_mem_rd_data : '0;

    assign almost_full_o   = r_almost_full;
    assign level_o         = r_level;
    assign drop_cnt_o      = r_drop_cnt;
    assign overflow_o      = r_overflow;

endmodule : aer_event_fifo
`default_nettype wire

// File: tb/tb_aer_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aer_event_fifo
//  Description : Directed self-checking bench for aer_event_fifo. Instance A
//                uses default sizing; instance B uses a 4-bit drop counter
//                to exercise saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aer_event_fifo;
    import lib_arbiter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic clr_a, flush_a, clr_b, flush_b;

    aer_event_fifo_if #(.DATA_W(WIDTH)) ifa ();
    aer_event_fifo_if #(.DATA_W(WIDTH)) ifb ();

    logic        af_a, ovf_a, af_b, ovf_b;
    logic [4:0]  lvl_a, lvl_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    aer_event_fifo #(.DATA_W(WIDTH), .DEPTH(16), .AFULL_TH(12), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .reset_i(reset_n), .bus(ifa),
        .almost_full_o(af_a), .level_o(lvl_a), .drop_cnt_o(cnt_a),
        .overflow_o(ovf_a), .clr_i(clr_a), .flush_i(flush_a)
    );

    aer_event_fifo #(.DATA_W(WIDTH), .DEPTH(16), .AFULL_TH(12), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .reset_i(reset_n), .bus(ifb),
        .almost_full_o(af_b), .level_o(lvl_b), .drop_cnt_o(cnt_b),
        .overflow_o(ovf_b), .clr_i(clr_b), .flush_i(flush_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_level"},  32'(lvl_a), 32'd0);
        chk({tag, "_valid"},  32'(ifa.out_valid_o), 32'd0);
        chk({tag, "_data"},   ifa.out_data_o, 32'd0);
        chk({tag, "_drop"},   32'(cnt_a), 32'd0);
        chk({tag, "_ovf"},    32'(ovf_a), 32'd0);
        chk({tag, "_afull"},  32'(af_a), 32'd0);
        chk({tag, "_ready"},  32'(ifa.evt_ready_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          exp_lvl;
        logic        rdy, vld, prev_stall;
        logic [31:0] prev_data;

        reset_n = 1'b0;
        clr_a = 1'b0; flush_a = 1'b0; clr_b = 1'b0; flush_b = 1'b0;
        ifa.evt_valid_i = 1'b0; ifa.evt_data_i = '0; ifa.out_ready_i = 1'b0;
        ifb.evt_valid_i = 1'b0; ifb.evt_data_i = '0; ifb.out_ready_i = 1'b0;
        prev_stall = 1'b0; prev_data = '0;

        // ---------------- reset state ----------------
        repeat (2) step();
        chk_reset_a("rst");
        reset_n = 1'b1;

        // ---------------- basic pass-through ----------------
        ifa.evt_valid_i = 1'b1; ifa.evt_data_i = 32'hA5; ifa.out_ready_i = 1'b1;
        step();
        chk("pt_valid", 32'(ifa.out_valid_o), 32'd1);
        chk("pt_data",  ifa.out_data_o, 32'hA5);
        chk("pt_level", 32'(lvl_a), 32'd1);
        ifa.evt_valid_i = 1'b0;
        step();
        chk("pt_level0", 32'(lvl_a), 32'd0);
        chk("pt_empty",  32'(ifa.out_valid_o), 32'd0);
        chk("pt_data0",  ifa.out_data_o, 32'd0);

        // ---------------- fill and drop ----------------
        ifa.out_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ifa.evt_valid_i = 1'b1;
            ifa.evt_data_i  = 32'h100 + 32'(i);
            if (i < 16) q.push_back(32'h100 + 32'(i));
            step();
            exp_lvl = (i + 1 > 16) ? 16 : i + 1;
            chk("fill_level", 32'(lvl_a), 32'(exp_lvl));
            chk("fill_afull", 32'(af_a), 32'(exp_lvl >= 12));
            chk("fill_ready", 32'(ifa.evt_ready_o), 32'(exp_lvl < 16));
        end
        ifa.evt_valid_i = 1'b0;
        chk("fill_drop", 32'(cnt_a), 32'd4);
        chk("fill_ovf",  32'(ovf_a), 32'd1);

        // ---------------- full with simultaneous read/write ----------------
        ifa.out_ready_i = 1'b1;
        ifa.evt_valid_i = 1'b1;
        for (int j = 0; j < 10; j++) begin
            ifa.evt_data_i = 32'h200 + 32'(j);
            chk("frw_head", ifa.out_data_o, q[0]);
            step();
            void'(q.pop_front());
            q.push_back(32'h200 + 32'(j));
            chk("frw_level", 32'(lvl_a), 32'd16);
            chk("frw_drop",  32'(cnt_a), 32'd4);
        end

        // ---------------- drain in order ----------------
        ifa.evt_valid_i = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", 32'(ifa.out_valid_o), 32'd1);
            chk("drain_head",  ifa.out_data_o, q[0]);
            step();
            void'(q.pop_front());
        end
        chk("drain_level", 32'(lvl_a), 32'd0);
        chk("drain_empty", 32'(ifa.out_valid_o), 32'd0);

        // ---------------- backpressure stability ----------------
        for (int n = 0; n < 40; n++) begin
            rdy = 1'($urandom_range(0, 1));
            vld = (q.size() < 14);
            ifa.out_ready_i = rdy;
            ifa.evt_valid_i = vld;
            ifa.evt_data_i  = 32'h300 + 32'(n);
            if (prev_stall) chk("bp_stable", ifa.out_data_o, prev_data);
            chk("bp_valid", 32'(ifa.out_valid_o), 32'(q.size() != 0));
            if (q.size() != 0) chk("bp_head", ifa.out_data_o, q[0]);
            prev_stall = (q.size() != 0) && !rdy;
            prev_data  = (q.size() != 0) ? q[0] : 32'd0;
            step();
            if ((q.size() != 0) && rdy) void'(q.pop_front());
            if (vld) q.push_back(32'h300 + 32'(n));
        end
        ifa.evt_valid_i = 1'b0;
        ifa.out_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q.size() != 0) begin
                chk("bp_drain", ifa.out_data_o, q[0]);
                step();
                void'(q.pop_front());
            end
        end
        chk("bp_level0", 32'(lvl_a), 32'd0);
        chk("bp_drop",   32'(cnt_a), 32'd4);

        // ---------------- clear / flush corners ----------------
        ifa.out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ifa.evt_valid_i = 1'b1;
            ifa.evt_data_i  = 32'h400 + 32'(i);
            step();
        end
        chk("cf_full", 32'(lvl_a), 32'd16);
        ifa.evt_data_i = 32'h4FF;
        clr_a = 1'b1;
        step();
        clr_a = 1'b0; ifa.evt_valid_i = 1'b0;
        chk("clrdrop_cnt", 32'(cnt_a), 32'd1);
        chk("clrdrop_ovf", 32'(ovf_a), 32'd1);
        chk("clrdrop_lvl", 32'(lvl_a), 32'd16);
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk("flush_level", 32'(lvl_a), 32'd0);
        chk("flush_valid", 32'(ifa.out_valid_o), 32'd0);
        chk("flush_ready", 32'(ifa.evt_ready_o), 32'd1);
        chk("flush_cnt",   32'(cnt_a), 32'd1);
        chk("flush_ovf",   32'(ovf_a), 32'd1);
        flush_a = 1'b1; ifa.evt_valid_i = 1'b1; ifa.evt_data_i = 32'h555;
        step();
        flush_a = 1'b0; ifa.evt_valid_i = 1'b0;
        chk("flushwr_level", 32'(lvl_a), 32'd0);
        step();
        chk("flushwr_level2", 32'(lvl_a), 32'd0);
        chk("flushwr_valid",  32'(ifa.out_valid_o), 32'd0);
        clr_a = 1'b1;
        step();
        clr_a = 1'b0;
        chk("clr_cnt", 32'(cnt_a), 32'd0);
        chk("clr_ovf", 32'(ovf_a), 32'd0);
        ifa.evt_valid_i = 1'b1; ifa.evt_data_i = 32'h666;
        step();
        ifa.evt_valid_i = 1'b0; ifa.out_ready_i = 1'b1;
        chk("postflush_data", ifa.out_data_o, 32'h666);
        step();
        chk("postflush_empty", 32'(lvl_a), 32'd0);

        // ---------------- drop counter saturation (CNT_W = 4) ----------------
        ifb.out_ready_i = 1'b0;
        for (int i = 0; i < 36; i++) begin
            ifb.evt_valid_i = 1'b1;
            ifb.evt_data_i  = 32'(i);
            step();
            if (i == 16) chk("sat_first", 32'(cnt_b), 32'd1);
            if (i == 30) chk("sat_reach", 32'(cnt_b), 32'd15);
        end
        ifb.evt_valid_i = 1'b0;
        chk("sat_cnt",   32'(cnt_b), 32'd15);
        chk("sat_ovf",   32'(ovf_b), 32'd1);
        chk("sat_level", 32'(lvl_b), 32'd16);

        // ---------------- asynchronous reset mid-burst ----------------
        ifa.out_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ifa.evt_valid_i = 1'b1;
            ifa.evt_data_i  = 32'h700 + 32'(i);
            step();
        end
        ifa.evt_valid_i = 1'b0;
        chk("ar_level7", 32'(lvl_a), 32'd7);
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_a("ar");
        chk("ar_b_level", 32'(lvl_b), 32'd0);
        chk("ar_b_cnt",   32'(cnt_b), 32'd0);
        #2;
        reset_n = 1'b1;
        step();
        chk("ar_post_level", 32'(lvl_a), 32'd0);
        chk("ar_post_valid", 32'(ifa.out_valid_o), 32'd0);
        chk("ar_post_ready", 32'(ifa.evt_ready_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_aer_event_fifo
`default_nettype wire
